// File: rtl/bcx_pkg.sv
// Shared types for the bcx result path: collector FSM states and the
// per-block result record handed to the host.
package bcx_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    REPORT = 2'd2
  } collector_state_t;

  typedef struct packed {
    logic               found;
    logic [NONCE_W-1:0] nonce;
  } ResultT;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that realigns the chain-tail valid/newblock
// flags with the processor results emerging LATENCY cycles later.
module valid_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 130
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] r_sr [DEPTH];

      // Shift the flag pair one stage per cycle; reset empties the pipe.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
      end

      assign q_o = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/bcx_result_collector.sv
// Tail of the processor chain: follows the nonce iteration of the current
// block and presents one result per block (winning nonce or exhausted) to
// the host over a valid/ready handshake.
module bcx_result_collector
  import bcx_pkg::*;
#(
  parameter int PARTITIONBITS = 1,
  parameter int LATENCY       = 130
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic                     newblock_i,
  input  logic                     victory_i,
  input  logic [PARTITIONBITS-1:0] nonce_start_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic                     result_found_o,
  output logic [NONCE_W-1:0]       result_nonce_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int ITER_W = NONCE_W - PARTITIONBITS;

  logic [1:0]       w_aligned;
  logic             w_dv;
  logic             w_dnb;
  logic             w_start;
  logic             w_beat;
  logic             w_accept;
  logic             w_iter_last;

  collector_state_t r_state;
  logic [ITER_W-1:0] r_iter;
  ResultT           r_result;
  logic             r_valid;
  logic             r_overrun;

  valid_delay_line #(
    .WIDTH (2),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i ({valid_i, newblock_i}),
    .q_o (w_aligned)
  );

  assign w_dv        = w_aligned[1];
  assign w_dnb       = w_aligned[0];
  assign w_start     = w_dv & w_dnb;
  assign w_beat      = w_dv & ~w_dnb;
  assign w_accept    = r_valid & result_ready_i;
  assign w_iter_last = &r_iter;

  // Block FSM, iteration counter and registered result/handshake outputs.
  // A new block wins over everything else; iteration 0 is evaluated on
  // the newblock beat itself, so a miss there leaves the counter at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_iter    <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_start) begin
        // Pending result not taken this cycle is lost to the new block.
        r_overrun <= r_valid & ~result_ready_i;
        if (victory_i) begin
          r_state        <= REPORT;
          r_valid        <= 1'b1;
          r_iter         <= '0;
          r_result.found <= 1'b1;
          r_result.nonce <= {{ITER_W{1'b0}}, nonce_start_i};
        end else begin
          r_state <= SEARCH;
          r_valid <= 1'b0;
          r_iter  <= ITER_W'(1);
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          SEARCH: begin
            if (w_beat) begin
              if (victory_i) begin
                r_state        <= REPORT;
                r_valid        <= 1'b1;
                r_result.found <= 1'b1;
                r_result.nonce <= {r_iter, nonce_start_i};
              end else if (w_iter_last) begin
                r_state        <= REPORT;
                r_valid        <= 1'b1;
                r_result.found <= 1'b0;
                r_result.nonce <= '0;
              end else begin
                r_iter <= r_iter + ITER_W'(1);
              end
            end
          end
          REPORT: begin
            if (w_accept) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign result_valid_o = r_valid;
  assign result_found_o = r_result.found;
  assign result_nonce_o = r_result.nonce;
  assign busy_o         = (r_state != IDLE);
  assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_bcx_result_collector.sv
// Bench for bcx_result_collector: two instances (PARTITIONBITS 1 and 31,
// LATENCY 4) share one stimulus stream and are compared against a
// beat-counting reference model of the result protocol.
module tb_bcx_result_collector;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        newblock_i;
  logic        victory_i;
  logic [31:0] ns;
  logic        ready;

  logic        rv_a, rf_a, busy_a, ovr_a;
  logic [31:0] rn_a;
  logic        rv_b, rf_b, busy_b, ovr_b;
  logic [31:0] rn_b;

  int checks = 0;
  int errors = 0;

  bcx_result_collector #(.PARTITIONBITS(1), .LATENCY(LAT)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .newblock_i     (newblock_i),
    .victory_i      (victory_i),
    .nonce_start_i  (ns[0:0]),
    .result_valid_o (rv_a),
    .result_ready_i (ready),
    .result_found_o (rf_a),
    .result_nonce_o (rn_a),
    .busy_o         (busy_a),
    .overrun_o      (ovr_a)
  );

  bcx_result_collector #(.PARTITIONBITS(31), .LATENCY(LAT)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .newblock_i     (newblock_i),
    .victory_i      (victory_i),
    .nonce_start_i  (ns[30:0]),
    .result_valid_o (rv_b),
    .result_ready_i (ready),
    .result_found_o (rf_b),
    .result_nonce_o (rn_b),
    .busy_o         (busy_b),
    .overrun_o      (ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, whether a block is open, the index of
  // the next beat within it, and the result waiting for the host.
  int                pbits [2] = '{1, 31};
  bit                m_pend [2];
  bit                m_pf   [2];
  logic [31:0]       m_pn   [2];
  bit                m_open [2];
  bit                m_ovr  [2];
  longint unsigned   m_cnt  [2];
  bit                hq_v [$];
  bit                hq_nb [$];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 0; m_pf[m] = 0; m_pn[m] = '0;
      m_open[m] = 0; m_ovr[m] = 0; m_cnt[m] = 0;
    end
    hq_v.delete();
    hq_nb.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    valid_i = 0; newblock_i = 0; victory_i = 0; ns = '0; ready = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model, then let the edge pass.
  task automatic step(input bit v, input bit nb, input bit vic,
                      input logic [31:0] s, input bit r);
    bit dv, dnb, acc;
    logic [31:0] mask, nsv;
    longint unsigned maxcnt, tmp;
    valid_i = v; newblock_i = nb; victory_i = vic; ns = s; ready = r;
    hq_v.push_back(v);
    hq_nb.push_back(nb);
    dv = 0; dnb = 0;
    if (hq_v.size() > LAT) begin
      dv  = hq_v.pop_front();
      dnb = hq_nb.pop_front();
    end
    for (int m = 0; m < 2; m++) begin
      mask   = (32'h1 << pbits[m]) - 32'h1;
      nsv    = s & mask;
      maxcnt = (64'd1 << (32 - pbits[m])) - 64'd1;
      acc    = m_pend[m] && r;
      m_ovr[m] = 0;
      if (dv && dnb) begin
        if (m_pend[m] && !acc) m_ovr[m] = 1;
        if (vic) begin
          m_pend[m] = 1; m_pf[m] = 1; m_pn[m] = nsv; m_open[m] = 0;
        end else begin
          m_pend[m] = 0; m_open[m] = 1; m_cnt[m] = 1;
        end
      end else begin
        if (acc) m_pend[m] = 0;
        if (dv && m_open[m]) begin
          if (vic) begin
            tmp = (m_cnt[m] << pbits[m]) | longint'(nsv);
            m_pend[m] = 1; m_pf[m] = 1; m_pn[m] = tmp[31:0]; m_open[m] = 0;
          end else if (m_cnt[m] == maxcnt) begin
            m_pend[m] = 1; m_pf[m] = 0; m_pn[m] = '0; m_open[m] = 0;
          end else begin
            m_cnt[m] = m_cnt[m] + 1;
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_i = 0; newblock_i = 0; victory_i = 0; ns = '0; ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rv_a, rf_a, busy_a, ovr_a, rn_a} !== 36'h0) begin
      errors++;
      $display("FAIL reset_a: got v=%b f=%b b=%b o=%b n=%h, want all 0",
               rv_a, rf_a, busy_a, ovr_a, rn_a);
    end
    checks++;
    if ({rv_b, rf_b, busy_b, ovr_b, rn_b} !== 36'h0) begin
      errors++;
      $display("FAIL reset_b: got v=%b f=%b b=%b o=%b n=%h, want all 0",
               rv_b, rf_b, busy_b, ovr_b, rn_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_found_hold();
    apply_reset();
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h1, 0);  // third aligned beat wins, processor 1
    checks++;
    if (rv_a !== 1'b1 || rf_a !== 1'b1 || rn_a !== 32'h5) begin
      errors++;
      $display("FAIL found_nonce5: got v=%b f=%b n=%h, want v=1 f=1 n=00000005",
               rv_a, rf_a, rn_a);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (rv_a !== 1'b1 || rn_a !== 32'h5 || rf_a !== 1'b1) begin
        errors++;
        $display("FAIL found_hold%0d: got v=%b f=%b n=%h, want v=1 f=1 n=00000005",
                 i, rv_a, rf_a, rn_a);
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (rv_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL found_accept: got v=%b busy=%b, want v=0 busy=0", rv_a, busy_a);
    end
  endtask

  task automatic test_victory_on_newblock();
    apply_reset();
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0, 0);
    checks++;
    if (rv_a !== 1'b1 || rf_a !== 1'b1 || rn_a !== 32'h0) begin
      errors++;
      $display("FAIL nb_victory_a: got v=%b f=%b n=%h, want v=1 f=1 n=00000000",
               rv_a, rf_a, rn_a);
    end
    checks++;
    if (rv_b !== 1'b1 || rf_b !== 1'b1 || rn_b !== 32'h0) begin
      errors++;
      $display("FAIL nb_victory_b: got v=%b f=%b n=%h, want v=1 f=1 n=00000000",
               rv_b, rf_b, rn_b);
    end
  endtask

  task automatic test_exhaust31();
    apply_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 32'h3, 0);
    step(0, 0, 0, 32'h3, 0);
    checks++;
    if (rv_b !== 1'b1 || rf_b !== 1'b0 || rn_b !== 32'h0) begin
      errors++;
      $display("FAIL exhaust_b: got v=%b f=%b n=%h, want v=1 f=0 n=00000000",
               rv_b, rf_b, rn_b);
    end
    checks++;
    if (busy_a !== 1'b1 || rv_a !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_a_searching: got busy=%b v=%b, want busy=1 v=0",
               busy_a, rv_a);
    end
    apply_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h12345679, 0);  // victory on the last iteration
    checks++;
    if (rv_b !== 1'b1 || rf_b !== 1'b1 || rn_b !== 32'h92345679) begin
      errors++;
      $display("FAIL last_iter_victory_b: got v=%b f=%b n=%h, want v=1 f=1 n=92345679",
               rv_b, rf_b, rn_b);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);          // second block, lands while first pending
    step(0, 0, 1, 32'h1, 0);      // first block wins at iteration 0
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);          // second newblock aligned, ready=0
    checks++;
    if (ovr_a !== 1'b1 || rv_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got o=%b v=%b busy=%b, want o=1 v=0 busy=1",
               ovr_a, rv_a, busy_a);
    end
    step(1, 1, 0, 0, 0);
    checks++;
    if (ovr_a !== 1'b0) begin
      errors++;
      $display("FAIL overrun_one_cycle: got o=%b, want 0", ovr_a);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h0, 0);      // third block wins on its newblock beat
    checks++;
    if (rv_a !== 1'b1 || rn_a !== 32'h0 || rf_a !== 1'b1) begin
      errors++;
      $display("FAIL overrun_setup: got v=%b f=%b n=%h, want v=1 f=1 n=00000000",
               rv_a, rf_a, rn_a);
    end
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);          // accept coincides with aligned newblock
    checks++;
    if (ovr_a !== 1'b0 || rv_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL accept_with_newblock: got o=%b v=%b busy=%b, want o=0 v=0 busy=1",
               ovr_a, rv_a, busy_a);
    end
  endtask

  task automatic test_ignored();
    apply_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32'h1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 32'h1, 0);
      checks++;
      if (rv_a !== 1'b0 || busy_a !== 1'b0 || rv_b !== 1'b0 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL ignored%0d: got va=%b ba=%b vb=%b bb=%b, want all 0",
                 i, rv_a, busy_a, rv_b, busy_b);
      end
    end
  endtask

  task automatic test_reset_mid_report();
    apply_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h1, 0);
    checks++;
    if (rv_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_report_setup: got v=%b, want 1", rv_a);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rv_a !== 1'b0 || busy_a !== 1'b0 || ovr_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b busy=%b o=%b, want all 0",
               rv_a, busy_a, ovr_a);
    end
    model_reset();
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 32'h1, 0);
      checks++;
      if (rv_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle%0d: got v=%b busy=%b, want 0 0", i, rv_a, busy_a);
      end
    end
  endtask

  task automatic test_random();
    bit          v, nb, vic, r;
    bit          av, af, ab, ao;
    logic [31:0] an;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      v   = ($urandom % 4) != 0;
      nb  = v && (($urandom % 10) == 0);
      vic = ($urandom % 6) == 0;
      r   = ($urandom % 3) == 0;
      step(v, nb, vic, $urandom, r);
      for (int m = 0; m < 2; m++) begin
        av = (m == 0) ? rv_a   : rv_b;
        af = (m == 0) ? rf_a   : rf_b;
        an = (m == 0) ? rn_a   : rn_b;
        ab = (m == 0) ? busy_a : busy_b;
        ao = (m == 0) ? ovr_a  : ovr_b;
        checks++;
        if (av !== m_pend[m] || ab !== (m_pend[m] | m_open[m]) || ao !== m_ovr[m]) begin
          errors++;
          $display("FAIL rand_ctrl dut%0d cyc%0d: got v=%b busy=%b o=%b, want v=%b busy=%b o=%b",
                   m, c, av, ab, ao, m_pend[m], m_pend[m] | m_open[m], m_ovr[m]);
        end
        if (m_pend[m]) begin
          checks++;
          if (af !== m_pf[m] || an !== m_pn[m]) begin
            errors++;
            $display("FAIL rand_result dut%0d cyc%0d: got f=%b n=%h, want f=%b n=%h",
                     m, c, af, an, m_pf[m], m_pn[m]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_found_hold();
    test_victory_on_newblock();
    test_exhaust31();
    test_overrun();
    test_ignored();
    test_reset_mid_report();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
